// File: rtl/hex_ctrl_pkg.sv
// Shared encodings and width helpers for the HEX0 display controller.
package hex_ctrl_pkg;

   localparam logic [1:0] MODE_SW    = 2'b00;
   localparam logic [1:0] MODE_CNT4  = 2'b01;
   localparam logic [1:0] MODE_CNT30 = 2'b10;
   localparam logic [1:0] MODE_OFF   = 2'b11;

   typedef enum logic [2:0] {
      ST_SW,
      ST_CNT4,
      ST_CNT30,
      ST_OFF,
      ST_SWITCH
   } hex_state_e;

   // Bits needed to count 0..n-1 (never less than one bit).
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int deb_w(input int debounce_cycles);
      return cnt_w(debounce_cycles);
   endfunction

   // Blank counter holds the full load value, so it needs one extra code.
   function automatic int blank_w(input int blank_cycles);
      return cnt_w(blank_cycles + 1);
   endfunction

   function automatic hex_state_e mode_state(input logic [1:0] mode);
      case (mode)
         MODE_CNT4:  return ST_CNT4;
         MODE_CNT30: return ST_CNT30;
         MODE_OFF:   return ST_OFF;
         default:    return ST_SW;
      endcase
   endfunction

endpackage

// File: rtl/key_debounce.sv
// KEY3 synchronizer and debouncer; emits a one-cycle pulse on an accepted press.
module key_debounce
   import hex_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic press
);

   localparam int CW = deb_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          key_m;
   logic          key_s;
   logic          stable;
   logic          stable_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         key_m    <= 1'b1;
         key_s    <= 1'b1;
         stable   <= 1'b1;
         stable_d <= 1'b1;
         cnt      <= '0;
         press    <= 1'b0;
      end else begin
         key_m    <= key_n;
         key_s    <= key_m;
         stable_d <= stable;
         press    <= stable_d & ~stable;
         // Any sample agreeing with the stable level restarts the run.
         if (key_s == stable) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            stable <= key_s;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/hex_display_ctrl.sv
// HEX0 display sequencer: mode FSM with blanking on mode change and
// registered strobes to the press counter and the free-running counter.
module hex_display_ctrl
   import hex_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int BLANK_CYCLES    = 4
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [1:0] sw_mode,
   input  logic [3:0] sw_val,
   input  logic       key_n,
   input  logic [3:0] cnt4_val,
   input  logic [3:0] cnt30_nib,
   output logic       cnt4_en,
   output logic       cnt4_clr,
   output logic       cnt30_en,
   output logic       cnt30_clr,
   output logic [3:0] dec_nibble,
   output logic       dec_blank,
   output logic [1:0] mode_cur
);

   localparam int BW = blank_w(BLANK_CYCLES);
   localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);

   logic [1:0]    mode_m;
   logic [1:0]    mode_s;
   logic          press;

   hex_state_e    state, state_nx;
   logic [1:0]    target, target_nx;
   logic [BW-1:0] blank_cnt, blank_cnt_nx;
   logic [1:0]    mode_nx;
   logic          press_ok;
   logic          cnt4_en_nx, cnt4_clr_nx, cnt30_en_nx, cnt30_clr_nx;
   logic [3:0]    nibble_nx;
   logic          blank_nx;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key (
      .clk   (CLOCK_50),
      .reset (reset),
      .key_n (key_n),
      .press (press)
   );

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         mode_m     <= MODE_SW;
         mode_s     <= MODE_SW;
         state      <= ST_SW;
         target     <= MODE_SW;
         blank_cnt  <= '0;
         mode_cur   <= MODE_SW;
         cnt4_en    <= 1'b0;
         cnt4_clr   <= 1'b0;
         cnt30_en   <= 1'b0;
         cnt30_clr  <= 1'b0;
         dec_nibble <= 4'h0;
         dec_blank  <= 1'b1;
      end else begin
         mode_m     <= sw_mode;
         mode_s     <= mode_m;
         state      <= state_nx;
         target     <= target_nx;
         blank_cnt  <= blank_cnt_nx;
         mode_cur   <= mode_nx;
         cnt4_en    <= cnt4_en_nx;
         cnt4_clr   <= cnt4_clr_nx;
         cnt30_en   <= cnt30_en_nx;
         cnt30_clr  <= cnt30_clr_nx;
         dec_nibble <= nibble_nx;
         dec_blank  <= blank_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      target_nx    = target;
      blank_cnt_nx = blank_cnt;
      mode_nx      = mode_cur;
      press_ok     = 1'b0;
      cnt4_en_nx   = 1'b0;
      cnt4_clr_nx  = 1'b0;
      cnt30_en_nx  = 1'b0;
      cnt30_clr_nx = 1'b0;
      nibble_nx    = 4'h0;
      blank_nx     = 1'b1;

      // A new mode request takes priority over both exit and presses.
      if (state == ST_SWITCH) begin
         if (mode_s != target) begin
            target_nx    = mode_s;
            blank_cnt_nx = BLANK_LOAD;
         end else if (blank_cnt == BW'(1)) begin
            state_nx = mode_state(target);
            mode_nx  = target;
         end else begin
            blank_cnt_nx = blank_cnt - BW'(1);
         end
      end else if (mode_s != mode_cur) begin
         state_nx     = ST_SWITCH;
         target_nx    = mode_s;
         blank_cnt_nx = BLANK_LOAD;
      end else begin
         press_ok = press;
      end

      // Outputs are registered from the state being entered.
      case (state_nx)
         ST_SW: begin
            nibble_nx = sw_val;
            blank_nx  = 1'b0;
         end
         ST_CNT4: begin
            nibble_nx  = cnt4_val;
            blank_nx   = 1'b0;
            cnt4_en_nx = press_ok;
         end
         ST_CNT30: begin
            nibble_nx    = cnt30_nib;
            blank_nx     = 1'b0;
            cnt30_en_nx  = ~press_ok;
            cnt30_clr_nx = press_ok;
         end
         ST_SWITCH: begin
            cnt4_clr_nx  = (target_nx == MODE_CNT4);
            cnt30_clr_nx = (target_nx == MODE_CNT30);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed and randomized checks of hex_display_ctrl against a cycle model.
module tb_hex_display_ctrl;

   localparam int DEB = 8;
   localparam int BLK = 4;

   logic       clk;
   logic       reset;
   logic [1:0] sw_mode;
   logic [3:0] sw_val;
   logic       key_n;
   logic [3:0] cnt4_val;
   logic [3:0] cnt30_nib;
   logic       cnt4_en, cnt4_clr, cnt30_en, cnt30_clr;
   logic [3:0] dec_nibble;
   logic       dec_blank;
   logic [1:0] mode_cur;

   int checks = 0;
   int errors = 0;

   hex_display_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .BLANK_CYCLES   (BLK)
   ) dut (
      .CLOCK_50  (clk),
      .reset     (reset),
      .sw_mode   (sw_mode),
      .sw_val    (sw_val),
      .key_n     (key_n),
      .cnt4_val  (cnt4_val),
      .cnt30_nib (cnt30_nib),
      .cnt4_en   (cnt4_en),
      .cnt4_clr  (cnt4_clr),
      .cnt30_en  (cnt30_en),
      .cnt30_clr (cnt30_clr),
      .dec_nibble(dec_nibble),
      .dec_blank (dec_blank),
      .mode_cur  (mode_cur)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Cycle model: two-stage input delay, run-length debounce, and a mode
   // tracker that counts down the blank period.
   int         m_sm0, m_sm1, m_mode, m_target, m_left, m_run, ms;
   bit         m_k0, m_k1, m_stable, m_fell, m_press, m_sw, primed, pr, took;
   logic [3:0] nib;
   bit         blk, en4, clr4, en30, clr30;
   logic [10:0] e_out;

   initial primed = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_sm0 = 0; m_sm1 = 0; m_k0 = 1; m_k1 = 1;
         m_stable = 1; m_run = 0; m_fell = 0; m_press = 0;
         m_mode = 0; m_sw = 0; m_target = 0; m_left = 0;
         e_out = {4'b0000, 4'h0, 1'b1, 2'b00};
      end else begin
         ms = m_sm1;
         pr = m_press;
         took = 0;
         m_sm1 = m_sm0;
         m_sm0 = int'(sw_mode);
         m_press = m_fell;
         m_fell = 0;
         if (m_k1 != m_stable) begin
            m_run++;
            if (m_run == DEB) begin
               m_fell = m_stable;
               m_stable = m_k1;
               m_run = 0;
            end
         end else m_run = 0;
         m_k1 = m_k0;
         m_k0 = key_n;

         if (m_sw) begin
            if (ms != m_target) begin
               m_target = ms;
               m_left = BLK;
            end else begin
               m_left--;
               if (m_left == 0) begin
                  m_sw = 0;
                  m_mode = m_target;
               end
            end
         end else if (ms != m_mode) begin
            m_sw = 1;
            m_target = ms;
            m_left = BLK;
         end else took = pr;

         en4 = 0; clr4 = 0; en30 = 0; clr30 = 0; nib = 4'h0; blk = 1;
         if (m_sw) begin
            clr4 = (m_target == 1);
            clr30 = (m_target == 2);
         end else begin
            case (m_mode)
               0: begin nib = sw_val; blk = 0; end
               1: begin nib = cnt4_val; blk = 0; en4 = took; end
               2: begin nib = cnt30_nib; blk = 0; en30 = !took; clr30 = took; end
               default: ;
            endcase
         end
         e_out = {en4, clr4, en30, clr30, nib, blk, 2'(m_mode)};
      end
      primed = 1'b1;
   end

   always @(negedge clk) begin
      if (primed)
         chk("outputs", 16'({cnt4_en, cnt4_clr, cnt30_en, cnt30_clr, dec_nibble, dec_blank, mode_cur}),
             16'(e_out));
   end

   int mh, kh;

   initial begin
      reset = 1; sw_mode = 2'b01; key_n = 1; sw_val = 4'h0;
      cnt4_val = 4'h5; cnt30_nib = 4'h9;

      // Reset, then the pending mode 01 forces a blank/clear sequence.
      tick(3);
      chk("rst_mode", 16'(mode_cur), 16'd0);
      chk("rst_blank", 16'(dec_blank), 16'd1);
      chk("rst_strobes", 16'({cnt4_en, cnt4_clr, cnt30_en, cnt30_clr}), 16'd0);
      chk("rst_nibble", 16'(dec_nibble), 16'd0);
      reset = 0;
      tick(3);
      chk("sw_clr4", 16'({cnt4_clr, dec_blank, mode_cur}), 16'b1_1_00);
      tick(3);
      chk("sw_clr4_hold", 16'({cnt4_clr, dec_blank, mode_cur}), 16'b1_1_00);
      tick(1);
      chk("enter_cnt4", 16'({cnt4_clr, dec_blank, mode_cur, dec_nibble}), 16'b0_0_01_0101);

      // Clean press.
      key_n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         chk("clean_press", 16'(cnt4_en), 16'(i == 12));
      end
      key_n = 1;
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         chk("release", 16'(cnt4_en), 16'd0);
      end

      // Bouncy press.
      for (int s = 0; s < 10; s++) begin
         key_n = (s % 2 == 0) ? 1'b0 : 1'b1;
         for (int j = 0; j < 3; j++) begin
            tick(1);
            chk("bounce", 16'(cnt4_en), 16'd0);
         end
      end
      key_n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         chk("bounce_press", 16'(cnt4_en), 16'(i == 12));
      end
      key_n = 1;
      tick(15);

      // Switches mode.
      sw_mode = 2'b00; sw_val = 4'hA;
      tick(10);
      chk("sw_nib_a", 16'({dec_nibble, dec_blank, mode_cur}), 16'b1010_0_00);
      sw_val = 4'h3;
      tick(1);
      chk("sw_nib_3", 16'(dec_nibble), 16'h3);

      // 30-bit mode press.
      sw_mode = 2'b10;
      tick(10);
      chk("cnt30_run", 16'({cnt30_en, mode_cur, dec_nibble}), 16'b1_10_1001);
      key_n = 0;
      for (int i = 1; i <= 14; i++) begin
         tick(1);
         chk("cnt30_clr", 16'(cnt30_clr), 16'(i == 12));
         chk("cnt30_en", 16'(cnt30_en), 16'(i != 12));
      end
      key_n = 1;
      tick(15);

      // Mode change mid-switch.
      sw_mode = 2'b00;
      tick(10);
      sw_mode = 2'b10;
      tick(3);
      chk("mid_clr30", 16'({cnt30_clr, dec_blank, mode_cur}), 16'b1_1_00);
      sw_mode = 2'b11;
      tick(2);
      chk("mid_clr30_hold", 16'(cnt30_clr), 16'd1);
      tick(1);
      chk("mid_retarget", 16'({cnt30_clr, dec_blank, mode_cur}), 16'b0_1_00);
      tick(3);
      chk("mid_still_old", 16'(mode_cur), 16'd0);
      tick(1);
      chk("mid_off", 16'({mode_cur, dec_blank, dec_nibble}), 16'b11_1_0000);

      // Randomized phase against the model.
      mh = 0; kh = 0;
      for (int c = 0; c < 4000; c++) begin
         sw_val = 4'($urandom);
         cnt4_val = 4'($urandom);
         cnt30_nib = 4'($urandom);
         if (mh == 0) begin
            sw_mode = 2'($urandom);
            mh = $urandom_range(1, 40);
         end else mh--;
         if (kh == 0) begin
            key_n = ~key_n;
            kh = $urandom_range(1, 14);
         end else kh--;
         reset = ($urandom_range(0, 599) == 0);
         tick(1);
      end
      reset = 0;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Synchronous controller for the HEX0 display datapath: the 4-bit press counter, the free-running 30-bit counter and the seven-segment decoder.
- Sequences them from the mode switches and KEY3.
- Replaces the combinational mode mux with:
  - synchronized, debounced key handling,
  - registered counter enable/clear strobes,
  - a blanking transition on every mode change.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a key level change is accepted (20 ms at 50 MHz).
- BLANK_CYCLES, 4, cycles the display is blanked and the target counter cleared on a mode change.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sw_mode  in  2  SW[9:8], asynchronous. 00 switches, 01 4-bit counter, 10 30-bit counter, 11 off.
- sw_val  in  4  SW[3:0], displayed in mode 00.
- key_n  in  1  KEY3, active-low, asynchronous, bouncy.
- cnt4_val  in  4  4-bit counter value.
- cnt30_nib  in  4  displayed nibble of the 30-bit counter.
- cnt4_en  out  1  one-cycle increment strobe to the 4-bit counter.
- cnt4_clr  out  1  clear strobe to the 4-bit counter.
- cnt30_en  out  1  count enable level to the 30-bit counter.
- cnt30_clr  out  1  clear strobe to the 30-bit counter.
- dec_nibble  out  4  decoder input.
- dec_blank  out  1  1 = segments off.
- mode_cur  out  2  currently active mode.

Behaviour:
- **Synchronizers:** sw_mode and key_n each pass through a 2-flop synchronizer. Reset values: sw_mode 00, key_n 1.
- **Debounce:**
  - The counter restarts whenever the synced key equals the stable level.
  - The stable level flips after DEBOUNCE_CYCLES consecutive differing samples.
  - press = one-cycle pulse on a stable 1->0 transition. Release produces no pulse.
- **Press latency:** key_n held low from sampling edge t produces press at cycle t+DEBOUNCE_CYCLES+2. The registered strobe appears at t+DEBOUNCE_CYCLES+3.
- **FSM states:** ST_SW, ST_CNT4, ST_CNT30, ST_OFF, ST_SWITCH.
- **Entering a mode change:**
  - In any steady state, synced mode != mode_cur moves the FSM to ST_SWITCH next cycle.
  - On entry: target latched, blank counter loaded with BLANK_CYCLES.
- **During ST_SWITCH:**
  - Outputs: dec_blank=1, cnt4_en=0, cnt30_en=0.
  - Clear: cnt4_clr=1 if target 01, cnt30_clr=1 if target 10. Both are held for all blank cycles.
  - mode_cur keeps the old mode.
  - Presses are ignored.
- **Exit from ST_SWITCH:**
  - After BLANK_CYCLES cycles the FSM enters the target state and mode_cur updates.
  - A mode change during ST_SWITCH re-latches the target and restarts the count.
  - Returning to the old mode mid-switch is treated as a new target and still completes the blanking.
- **ST_SW:** dec_nibble=sw_val, cnt30_en=0, presses ignored.
- **ST_CNT4:**
  - Outputs: dec_nibble=cnt4_val, cnt30_en=0.
  - Each press gives cnt4_en=1 for exactly one cycle.
  - Wrap 15->0 is owned by the counter; the controller does not care.
- **ST_CNT30:**
  - Outputs: dec_nibble=cnt30_nib, cnt30_en=1.
  - A press gives cnt30_clr=1 and cnt30_en=0 for one cycle.
- **ST_OFF:** dec_blank=1, dec_nibble=0, presses ignored.
- **Simultaneous press and mode change:** the mode change wins and the press is dropped.
- **Output timing:** all outputs are registered. dec_nibble follows its selected input with 1-cycle latency. Whenever dec_blank=1, dec_nibble=0.
- **Reset values:**
  - State ST_SW, mode_cur=00.
  - Stable key 1, debounce counter 0.
  - dec_nibble=0, dec_blank=1.
  - All en/clr outputs 0.
  - Reset mid-switch or mid-debounce aborts the operation to these values. dec_blank deasserts the cycle after reset release.

Decomposition:
- **Package hex_ctrl_pkg:**
  - Mode encodings MODE_SW=2'b00, MODE_CNT4=2'b01, MODE_CNT30=2'b10, MODE_OFF=2'b11.
  - FSM state enum.
  - Width helpers built on $clog2 of DEBOUNCE_CYCLES and BLANK_CYCLES.
- **Sub-module key_debounce:** 2-flop sync, debounce counter and falling-edge press pulse, parameterized by DEBOUNCE_CYCLES. The top level keeps the sw_mode synchronizer and the FSM.

Test Plan (DEBOUNCE_CYCLES=8, BLANK_CYCLES=4):
1. **Reset:** reset high 3 cycles with sw_mode=01 -> during reset, state ST_SW, mode_cur=00, dec_blank=1, all strobes 0. After release, ST_SWITCH is entered and cnt4_clr=1 for 4 cycles, then mode_cur=01.
2. **Switches mode:** sw_mode=00, sw_val=4'hA -> dec_nibble=A, dec_blank=0. Change sw_val to 3 -> dec_nibble=3 one cycle later.
3. **Clean press:** mode 01, key_n low at edge t and held 20 cycles -> cnt4_en=1 only at t+11. Release produces no pulse.
4. **Bouncy press:** key_n toggling every 3 cycles for 30 cycles, then low -> no cnt4_en during toggling. Exactly one pulse 11 cycles after the final low.
5. **30-bit mode:** mode 10 with cnt30_en=1, press -> cnt30_clr=1 and cnt30_en=0 for one cycle, then cnt30_en=1.
6. **Mode change mid-switch:** sw_mode 00->10, then ->11 two cycles into ST_SWITCH -> blank restarts and cnt30_clr deasserts. After 4 cycles mode_cur=11 and dec_blank stays 1.
